uart_io_bridge: RTL

Host debug bridge and a second initiator on the 16-bit io bus. It consumes bytes from a `buart`-style receive handshake, decodes a small framed command protocol, and issues single-cycle `io_wr`/`io_rd` strobes. It returns read data or acknowledge bytes through the `buart` transmit handshake. It sits between a second UART instance and the peripheral io bus, so a host can poke peripherals without the CPU running.

---
 rtl/uart_io_bridge.sv | 127 ++++++++++++
 1 files changed

// File: rtl/uart_io_bridge.sv
// Host debug bridge: decodes framed read/write commands from a byte-stream UART
// and issues single-cycle io bus accesses, answering through the UART transmitter.
`timescale 1ns/1ps
module uart_io_bridge #(
  parameter int TIMEOUT = 1200000,
  parameter int TW      = 21
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_rd,
  input  logic        tx_busy,
  output logic        tx_wr,
  output logic [7:0]  tx_data,
  output logic        io_rd,
  output logic        io_wr,
  output logic [15:0] io_addr,
  output logic [15:0] io_dout,
  input  logic [15:0] io_din
);

  typedef enum logic [3:0] {
    S_IDLE, S_AHI, S_ALO, S_DHI, S_DLO, S_WR, S_RD, S_TX1, S_TX2
  } state_t;

  state_t        r_state, w_next;
  logic          r_write, r_pend, r_guard, r_rx_rd_q, r_run;
  logic [7:0]    r_tx_data, r_read_lo;
  logic [15:0]   r_addr, r_dout;
  logic [TW-1:0] r_cnt;
  logic          w_rx_phase, w_timeout, w_cmd_ok;

  assign w_rx_phase = (r_state inside {S_IDLE, S_AHI, S_ALO, S_DHI, S_DLO});
  assign w_timeout  = (r_cnt == TW'(TIMEOUT - 1));
  assign w_cmd_ok   = (rx_data == 8'h57) || (rx_data == 8'h52);

  assign tx_data = r_tx_data;
  assign io_addr = r_addr;
  assign io_dout = r_dout;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (rx_rd) w_next = w_cmd_ok ? S_AHI : S_TX1;
      S_AHI:  if (rx_rd) w_next = S_ALO;
              else if (w_timeout) w_next = S_IDLE;
      S_ALO:  if (rx_rd) w_next = r_write ? S_DHI : S_RD;
              else if (w_timeout) w_next = S_IDLE;
      S_DHI:  if (rx_rd) w_next = S_DLO;
              else if (w_timeout) w_next = S_IDLE;
      S_DLO:  if (rx_rd) w_next = S_WR;
              else if (w_timeout) w_next = S_IDLE;
      S_WR:   w_next = S_TX1;
      S_RD:   w_next = S_TX1;
      S_TX1:  if (tx_wr) w_next = r_pend ? S_TX2 : S_IDLE;
      S_TX2:  if (tx_wr) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // r_run keeps rx_rd low until the first edge after reset release.
  always_comb begin
    rx_rd = w_rx_phase && rx_valid && !r_rx_rd_q && r_run;
    tx_wr = ((r_state == S_TX1) || (r_state == S_TX2)) && !tx_busy && !r_guard;
    io_wr = (r_state == S_WR);
    io_rd = (r_state == S_RD);
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_run     <= 1'b0;
      r_rx_rd_q <= 1'b0;
      r_guard   <= 1'b0;
      r_write   <= 1'b0;
      r_pend    <= 1'b0;
      r_tx_data <= 8'h00;
      r_read_lo <= 8'h00;
      r_addr    <= 16'h0000;
      r_dout    <= 16'h0000;
      r_cnt     <= '0;
    end else begin
      r_run     <= 1'b1;
      r_rx_rd_q <= rx_rd;
      r_guard   <= tx_wr;

      if (rx_rd || (r_state == S_IDLE) || !w_rx_phase) r_cnt <= '0;
      else                                             r_cnt <= r_cnt + 1'b1;

      if (rx_rd) begin
        case (r_state)
          S_IDLE: begin
            r_write <= (rx_data == 8'h57);
            if (!w_cmd_ok) begin
              r_tx_data <= 8'h15;
              r_pend    <= 1'b0;
            end
          end
          S_AHI:   r_addr[15:8] <= rx_data;
          S_ALO:   r_addr[7:0]  <= rx_data;
          S_DHI:   r_dout[15:8] <= rx_data;
          S_DLO:   r_dout[7:0]  <= rx_data;
          default: ;
        endcase
      end

      if (r_state == S_WR) begin
        r_tx_data <= 8'h06;
        r_pend    <= 1'b0;
      end
      if (r_state == S_RD) begin
        r_read_lo <= io_din[7:0];
        r_tx_data <= io_din[15:8];
        r_pend    <= 1'b1;
      end
      // Swap in the low byte during the guard cycle so tx_data holds the high
      // byte through its own tx_wr and is ready before the next one can fire.
      if ((r_state == S_TX2) && r_guard) r_tx_data <= r_read_lo;
    end
  end

endmodule
